aes_block_sequencer: RTL and testbench
======================================

# aes_block_sequencer

Register-bus master that sits directly upstream of the AES-192 wrapper and drives its word-indexed register port. It accepts 128-bit plaintext blocks plus a key-slot select on a valid/ready stream. For each block it programs the key select and plaintext, pulses start, polls ct_valid and reads back the ciphertext. Ciphertext is presented on a valid/ready output stream, so software no longer has to sequence AES register traffic.

## Interface
Parameters:
- POLL_DELAY, 2: idle cycles after start deasserts before the first ct_valid poll (1..15).
- TIMEOUT_CYCLES, 1024: poll cycles allowed before abort; used only with AES_SEQ_TIMEOUT_EN.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset, asynchronous, active-high
- blk_valid_i  in  1  plaintext block valid
- blk_ready_o  out  1  sequencer can accept a block
- blk_data_i  in  128  plaintext/counter block
- blk_key_sel_i  in  2  key slot: 0 → key0, 1 → key1, 2/3 → key2
- ct_valid_o  out  1  ciphertext valid
- ct_ready_i  in  1  consumer accepts ciphertext
- ct_data_o  out  128  ciphertext
- err_o  out  1  one-cycle pulse: block aborted on timeout
- busy_o  out  1  state is not IDLE
- reg_en_o  out  1  register access enable
- reg_we_o  out  1  1 = write, 0 = read
- reg_addr_o  out  9  byte address, always word index << 3
- reg_wdata_o  out  64  write data, upper 32 bits zero
- reg_rdata_i  in  64  read data, combinational, valid in the same cycle as reg_en_o

## Operation
- Register indices:
  - 0: start
  - 1..4: plaintext words, blk_data[31:0] → idx1, [63:32] → idx2, [95:64] → idx3, [127:96] → idx4
  - 11: ct_valid, bit 0
  - 12..15: ct[31:0] .. ct[127:96]
  - 32: key_sel
- FSM states and transitions:
  - IDLE: blk_ready_o=1. On a valid&ready handshake, latch data and key_sel → WR_KSEL.
  - WR_KSEL: write idx32 = {62'b0, key_sel} → WR_PT.
  - WR_PT: four consecutive writes, idx1..4, with a 2-bit word counter → START_HI.
  - START_HI: write idx0 = 1 → START_LO.
  - START_LO: write idx0 = 0 → WAIT.
  - WAIT: reg_en_o=0 for POLL_DELAY cycles → POLL.
  - POLL: read idx11 every cycle.
    - reg_rdata_i[0]=1 → RD_CT.
    - Timeout (macro enabled): → ERR.
  - RD_CT: four reads, idx12..15, each captured into ct_data_o at its word position → OUT.
  - OUT: ct_valid_o=1, hold until ct_ready_i → IDLE.
  - ERR: err_o=1 for one cycle, block dropped, no ct output → IDLE.
- Every non-WAIT/OUT/IDLE/ERR state issues exactly one register access per cycle.
- reg_en_o=0 in IDLE, WAIT, OUT and ERR.
- Only one block is in flight; blk_ready_o=0 outside IDLE.
- ct_data_o and ct_valid_o stay stable while ct_valid_o=1 and ct_ready_i=0.
- Register lock zeroing: a locked read returns 0, so a locked ct_valid behaves as "not ready" and ends in timeout or an indefinite poll. This is intended; the sequencer does not inspect lock state.

## Timing
- Reset values: blk_ready_o=0 while rst_i is asserted, then 1 in IDLE. ct_valid_o=0, ct_data_o=0, err_o=0, busy_o=0, reg_en_o=0, reg_we_o=0, reg_addr_o=0, reg_wdata_o=0.
- Handshake at cycle 0. Writes occupy cycles 1–7: key_sel at 1, plaintext at 2–5, start at 6–7.
- Wait occupies cycles 8..7+POLL_DELAY; first poll at 8+POLL_DELAY.
- If ready is seen at poll cycle P, ct reads occur at P+1..P+4 and ct_valid_o rises at P+5.
- Minimum handshake-to-ct_valid latency is 13+POLL_DELAY cycles.
- Output handshake completes in the cycle where ct_valid_o & ct_ready_i; blk_ready_o=1 in the next cycle. There is no same-cycle bypass.
- blk_valid_i held while busy is ignored until IDLE.
- Reset mid-operation: async return to IDLE with all outputs at reset values. The wrapper's registers are not cleaned; the next block overwrites them.
- Timeout counter (16 bit) clears on entry to POLL. ERR is entered when the count reaches TIMEOUT_CYCLES−1 without ready.

## Configuration
- AES_SEQ_TIMEOUT_EN defined: timeout counter and ERR state are built; err_o pulses on abort.
- AES_SEQ_TIMEOUT_EN undefined: POLL waits indefinitely, err_o is tied to 0, TIMEOUT_CYCLES is unused.

## Structure
- Shared package aes_seq_pkg holds:
  - state enum typedef
  - register index constants: IDX_START=0, IDX_PT0=1, IDX_CTV=11, IDX_CT0=12, IDX_KSEL=32
- No sub-module; counters and capture registers are inline.

## Test plan
- Block 0x00112233_44556677_8899aabb_ccddeeff, key_sel=1, wrapper model with ct_valid after 20 cycles → write sequence idx32=1, idx1=0xccddeeff … idx4=0x00112233, idx0=1 then 0. ct_data_o equals the model ciphertext word-ordered; ct_valid_o rises at P+5.
- ct_ready_i held low for 10 cycles → ct_data_o and ct_valid_o stable, blk_ready_o=0; released → IDLE next cycle.
- Back-to-back: two blocks with blk_valid_i held high → second handshake occurs exactly one cycle after the first output handshake.
- With AES_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, model never sets ct_valid → 16 polls, single err_o pulse, no ct_valid_o, blk_ready_o=1 afterwards.
- rst_i asserted asynchronously mid-WR_PT → all outputs drop to reset values without waiting for a clock edge; a fresh block then completes normally.
- key_sel=3 → idx32 written with 3; POLL_DELAY=1 gives first poll at cycle 9.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types and register map for the AES block sequencer.
package aes_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_KSEL,
    ST_WR_PT,
    ST_START_HI,
    ST_START_LO,
    ST_WAIT,
    ST_POLL,
    ST_RD_CT,
    ST_OUT,
    ST_ERR
  } seq_state_e;

  localparam logic [5:0] IDX_START = 6'd0;
  localparam logic [5:0] IDX_PT0   = 6'd1;
  localparam logic [5:0] IDX_CTV   = 6'd11;
  localparam logic [5:0] IDX_CT0   = 6'd12;
  localparam logic [5:0] IDX_KSEL  = 6'd32;

  // The wrapper decodes 64-bit words, so byte address = word index * 8.
  function automatic logic [8:0] idx_to_addr(input logic [5:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/aes_block_sequencer.sv
// Register-bus master that pushes one plaintext block at a time through the AES-192 wrapper.
// Optional abort-on-timeout is built when AES_SEQ_TIMEOUT_EN is defined.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int POLL_DELAY     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [127:0] blk_data_i,
  input  logic [1:0]   blk_key_sel_i,
  output logic         ct_valid_o,
  input  logic         ct_ready_i,
  output logic [127:0] ct_data_o,
  output logic         err_o,
  output logic         busy_o,
  output logic         reg_en_o,
  output logic         reg_we_o,
  output logic [8:0]   reg_addr_o,
  output logic [63:0]  reg_wdata_o,
  input  logic [63:0]  reg_rdata_i
);

  localparam logic [3:0]  WAIT_LAST = 4'(POLL_DELAY - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  seq_state_e   state, state_next;
  logic [1:0]   word_cnt;
  logic [3:0]   wait_cnt;
  logic [127:0] blk_q;
  logic [1:0]   ksel_q;
  logic [127:0] ct_q;
  logic [5:0]   reg_idx;
  logic         tmo_hit;
  logic         unused_rdata;

  assign unused_rdata = ^reg_rdata_i[63:32];

`ifdef AES_SEQ_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (state == ST_WAIT) begin
      tmo_cnt <= '0;
    end else if (state == ST_POLL) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign err_o   = (state == ST_ERR);
`else
  logic unused_cfg;

  assign unused_cfg = ^TMO_LAST;
  assign tmo_hit    = 1'b0;
  assign err_o      = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_WR_PT || state == ST_RD_CT) begin
        word_cnt <= word_cnt + 2'd1;
      end
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
    end
  end

  // Block capture: payload only, not reset; the next block overwrites it.
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && blk_valid_i && blk_ready_o) begin
      blk_q  <= blk_data_i;
      ksel_q <= blk_key_sel_i;
    end
  end

  // Ciphertext capture is a visible output, so it clears on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ct_q <= '0;
    end else if (state == ST_RD_CT) begin
      ct_q[{word_cnt, 5'b0} +: 32] <= reg_rdata_i[31:0];
    end
  end

  always_comb begin
    state_next  = state;
    reg_en_o    = 1'b0;
    reg_we_o    = 1'b0;
    reg_idx     = IDX_START;
    reg_wdata_o = '0;
    case (state)
      ST_IDLE: begin
        if (blk_valid_i) state_next = ST_WR_KSEL;
      end
      ST_WR_KSEL: begin
        reg_en_o    = 1'b1;
        reg_we_o    = 1'b1;
        reg_idx     = IDX_KSEL;
        reg_wdata_o = {62'b0, ksel_q};
        state_next  = ST_WR_PT;
      end
      ST_WR_PT: begin
        reg_en_o    = 1'b1;
        reg_we_o    = 1'b1;
        reg_idx     = IDX_PT0 + {4'b0, word_cnt};
        reg_wdata_o = {32'b0, blk_q[{word_cnt, 5'b0} +: 32]};
        if (word_cnt == 2'd3) state_next = ST_START_HI;
      end
      ST_START_HI: begin
        reg_en_o    = 1'b1;
        reg_we_o    = 1'b1;
        reg_wdata_o = 64'd1;
        state_next  = ST_START_LO;
      end
      ST_START_LO: begin
        reg_en_o   = 1'b1;
        reg_we_o   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_next = ST_POLL;
      end
      ST_POLL: begin
        reg_en_o = 1'b1;
        reg_idx  = IDX_CTV;
        if (reg_rdata_i[0])  state_next = ST_RD_CT;
        else if (tmo_hit)    state_next = ST_ERR;
      end
      ST_RD_CT: begin
        reg_en_o = 1'b1;
        reg_idx  = IDX_CT0 + {4'b0, word_cnt};
        if (word_cnt == 2'd3) state_next = ST_OUT;
      end
      ST_OUT: begin
        if (ct_ready_i) state_next = ST_IDLE;
      end
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign reg_addr_o  = idx_to_addr(reg_idx);
  assign blk_ready_o = (state == ST_IDLE) && !rst_i;
  assign busy_o      = (state != ST_IDLE);
  assign ct_valid_o  = (state == ST_OUT);
  assign ct_data_o   = ct_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer with a behavioural AES wrapper register model.
// Timeout checks switch with AES_SEQ_TIMEOUT_EN.
module tb_aes_block_sequencer;

  localparam int PD  = 1;
  localparam int TMO = 16;
  localparam logic [127:0] K0 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [127:0] K1 = 128'h13579bdf_2468ace0_fedcba98_76543210;
  localparam logic [127:0] K2 = 128'hcafef00d_deadbeef_01234567_89abcdef;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [127:0] blk_data = '0;
  logic [1:0]   blk_ks = '0;
  logic         ct_valid;
  logic         ct_ready = 1'b0;
  logic [127:0] ct_data;
  logic         err;
  logic         busy;
  logic         reg_en;
  logic         reg_we;
  logic [8:0]   reg_addr;
  logic [63:0]  reg_wdata;
  logic [63:0]  reg_rdata;

  always #5 clk = ~clk;

  aes_block_sequencer #(.POLL_DELAY(PD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .blk_valid_i(blk_valid), .blk_ready_o(blk_ready),
    .blk_data_i(blk_data), .blk_key_sel_i(blk_ks),
    .ct_valid_o(ct_valid), .ct_ready_i(ct_ready), .ct_data_o(ct_data),
    .err_o(err), .busy_o(busy),
    .reg_en_o(reg_en), .reg_we_o(reg_we), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata)
  );

  function automatic logic [127:0] fake_ct(input logic [127:0] pt, input logic [1:0] ks);
    logic [127:0] k;
    k = (ks == 2'd0) ? K0 : (ks == 2'd1) ? K1 : K2;
    return {pt[63:0], pt[127:64]} ^ k;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper model: stores writes, raises ct_valid model_delay cycles after start.
  logic [127:0] w_pt = '0;
  logic [1:0]   w_ks = '0;
  logic         w_started = 1'b0;
  int           w_ready_at = 0;
  logic [127:0] w_ct = '0;
  int           model_delay = 0;
  bit           model_never = 1'b0;
  bit           model_force = 1'b0;
  logic         w_ctv;

  always @(posedge clk) begin
    if (reg_en && reg_we) begin
      case (reg_addr[8:3])
        6'd0: if (reg_wdata[0]) begin
          w_started  <= 1'b1;
          w_ready_at <= cyc + model_delay;
          w_ct       <= fake_ct(w_pt, w_ks);
        end
        6'd1, 6'd2, 6'd3, 6'd4: w_pt[(int'(reg_addr[8:3]) - 1) * 32 +: 32] <= reg_wdata[31:0];
        6'd32: w_ks <= reg_wdata[1:0];
        default: ;
      endcase
    end
  end

  always_comb w_ctv = w_started && (model_never ? model_force : (cyc >= w_ready_at));

  always_comb begin
    reg_rdata = '0;
    if (reg_en && !reg_we) begin
      if (reg_addr[8:3] == 6'd11)
        reg_rdata = {32'hdeadbeef, 31'b0, w_ctv};
      else if (reg_addr[8:3] >= 6'd12 && reg_addr[8:3] <= 6'd15)
        reg_rdata = {32'hdeadbeef, w_ct[(int'(reg_addr[8:3]) - 12) * 32 +: 32]};
    end
  end

  typedef struct {
    int          cyc;
    logic [8:0]  addr;
    logic [63:0] data;
  } acc_t;

  acc_t wr_q[$];
  acc_t rd_q[$];
  int   poll_q[$];
  int   err_cnt = 0;
  int   err_cyc = -1;

  always @(posedge clk) begin
    if (!rst) begin
      if (reg_en) begin
        if (reg_we)                  wr_q.push_back('{cyc, reg_addr, reg_wdata});
        else if (reg_addr == 9'd88)  poll_q.push_back(cyc);
        else                         rd_q.push_back('{cyc, reg_addr, 64'd0});
      end
      if (err) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic [1:0]   ks;
    int           delay;
    int           stall;
    logic [127:0] exp_ct;
    int           exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic [127:0] d, input logic [1:0] ks, input int dly, input int st);
    vec_t v;
    v.data    = d;
    v.ks      = ks;
    v.delay   = dly;
    v.stall   = st;
    v.exp_ct  = fake_ct(d, ks);
    v.exp_lat = (((8 + PD) > (6 + dly)) ? (8 + PD) : (6 + dly)) + 5;
    return v;
  endfunction

  task automatic wait_handshake(output int hs);
    hs = -1;
    for (int i = 0; i < 100; i++) begin
      if (blk_ready) begin
        hs = cyc;
        break;
      end
      @(negedge clk);
    end
    check_int("blk_handshake_seen", (hs >= 0) ? 1 : 0, 1);
  endtask

  task automatic run_block(input vec_t v, input bit keep_valid, output int hs, output int out_hs);
    int wb, pb, rb, rise, p_rel;
    bit stable;
    logic [5:0]  e_idx[7];
    logic [63:0] e_dat[7];
    model_delay = v.delay;
    model_never = 1'b0;
    model_force = 1'b0;
    blk_valid = 1'b1;
    blk_data  = v.data;
    blk_ks    = v.ks;
    ct_ready  = 1'b0;
    out_hs    = -1;
    wb = wr_q.size();
    pb = poll_q.size();
    rb = rd_q.size();
    wait_handshake(hs);
    if (hs < 0) return;
    @(negedge clk);
    if (!keep_valid) blk_valid = 1'b0;
    check_vec("busy_not_ready", {busy, blk_ready}, 2'b10);
    rise = -1;
    for (int i = 0; i < v.exp_lat + 100; i++) begin
      if (ct_valid) begin
        rise = cyc;
        break;
      end
      @(negedge clk);
    end
    check_int("ct_valid_latency", rise - hs, v.exp_lat);
    if (rise < 0) return;
    check_vec("ct_data", ct_data, v.exp_ct);
    e_idx = '{6'd32, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 6'd0};
    e_dat = '{64'(v.ks), 64'(v.data[31:0]), 64'(v.data[63:32]), 64'(v.data[95:64]),
              64'(v.data[127:96]), 64'd1, 64'd0};
    check_int("write_count", wr_q.size() - wb, 7);
    for (int i = 0; i < 7; i++) begin
      if (wb + i < wr_q.size()) begin
        check_int("write_cycle", wr_q[wb + i].cyc - hs, i + 1);
        check_vec("write_addr", wr_q[wb + i].addr, {e_idx[i], 3'b000});
        check_vec("write_data", wr_q[wb + i].data, e_dat[i]);
      end
    end
    p_rel = v.exp_lat - 5;
    check_int("poll_count", poll_q.size() - pb, p_rel - (8 + PD) + 1);
    if (poll_q.size() > pb) check_int("first_poll", poll_q[pb] - hs, 8 + PD);
    check_int("ct_read_count", rd_q.size() - rb, 4);
    for (int i = 0; i < 4; i++) begin
      if (rb + i < rd_q.size()) begin
        check_int("ct_read_cycle", rd_q[rb + i].cyc - hs, p_rel + 1 + i);
        check_vec("ct_read_addr", rd_q[rb + i].addr, 9'(8 * (12 + i)));
      end
    end
    stable = 1'b1;
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      if (!(ct_valid && ct_data == v.exp_ct && !blk_ready)) stable = 1'b0;
    end
    if (v.stall > 0) check_int("stall_hold", int'(stable), 1);
    ct_ready = 1'b1;
    out_hs   = cyc;
    @(negedge clk);
    ct_ready = 1'b0;
    check_vec("after_out_hs", {ct_valid, blk_ready, busy}, 3'b010);
  endtask

  vec_t vecs[7];
  int   hs, ohs, hs2, ohs2, pb, e0;
  bit   seen_ctv, done;

  initial begin
    vecs[0] = mk(128'h00112233_44556677_8899aabb_ccddeeff, 2'd1, 20, 0);
    vecs[1] = mk(128'hffeeddcc_bbaa9988_77665544_33221100, 2'd3, 0, 10);
    vecs[2] = mk(128'h01010101_02020202_03030303_04040404, 2'd0, 5, 2);
    vecs[3] = mk(128'h80000000_00000001_7fffffff_fffffffe, 2'd2, 9, 1);
    for (int i = 4; i < 7; i++)
      vecs[i] = mk({$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 30)), int'($urandom_range(0, 4)));

    @(negedge clk);
    check_vec("reset_outputs", {blk_ready, ct_valid, err, busy, reg_en, reg_we, reg_addr, reg_wdata}, '0);
    check_vec("reset_ct_data", ct_data, '0);
    rst = 1'b0;
    @(negedge clk);
    check_vec("idle_after_reset", {blk_ready, busy, reg_en}, 3'b100);

    for (int i = 0; i < 7; i++) run_block(vecs[i], 1'b0, hs, ohs);

    // Back-to-back: valid held across the first output handshake.
    run_block(vecs[2], 1'b1, hs, ohs);
    run_block(vecs[2], 1'b0, hs2, ohs2);
    check_int("b2b_second_hs", hs2 - ohs, 1);

    // Model never raises ct_valid.
    model_never = 1'b1;
    model_force = 1'b0;
    blk_valid = 1'b1;
    blk_data  = vecs[0].data;
    blk_ks    = vecs[0].ks;
    pb = poll_q.size();
    e0 = err_cnt;
    wait_handshake(hs);
    @(negedge clk);
    blk_valid = 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
    seen_ctv = 1'b0;
    done     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ct_valid) seen_ctv = 1'b1;
      if (blk_ready) begin
        done = 1'b1;
        break;
      end
    end
    check_int("timeout_returns_idle", int'(done), 1);
    check_int("timeout_poll_count", poll_q.size() - pb, TMO);
    if (poll_q.size() > pb) check_int("timeout_first_poll", poll_q[pb] - hs, 8 + PD);
    check_int("timeout_err_pulses", err_cnt - e0, 1);
    check_int("timeout_err_cycle", err_cyc - hs, 8 + PD + TMO);
    check_int("timeout_no_ct_valid", int'(seen_ctv), 0);
    check_vec("timeout_idle_outputs", {blk_ready, busy, err}, 3'b100);
`else
    repeat (40) @(negedge clk);
    check_vec("poll_forever_state", {busy, ct_valid, err, blk_ready}, 4'b1000);
    check_int("poll_forever_no_err", err_cnt - e0, 0);
    check_int("poll_forever_polls", poll_q.size() - pb, cyc - hs - (8 + PD));
    model_force = 1'b1;
    ohs  = cyc;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ct_valid) begin
        done = 1'b1;
        break;
      end
    end
    check_int("late_ready_latency", cyc - ohs, 5);
    check_vec("late_ready_ct", ct_data, vecs[0].exp_ct);
    ct_ready = 1'b1;
    @(negedge clk);
    ct_ready = 1'b0;
    check_vec("late_ready_idle", {ct_valid, blk_ready, busy}, 3'b010);
    model_never = 1'b0;
    model_force = 1'b0;
`endif

    // Asynchronous reset in the middle of the plaintext writes.
    model_never = 1'b0;
    blk_valid = 1'b1;
    blk_data  = vecs[3].data;
    blk_ks    = vecs[3].ks;
    wait_handshake(hs);
    @(negedge clk);
    blk_valid = 1'b0;
    @(negedge clk);
    check_vec("mid_wr_pt_write", {reg_en, reg_we, reg_addr}, {2'b11, 9'd8});
    #2 rst = 1'b1;
    #1;
    check_vec("async_reset_outputs", {blk_ready, ct_valid, err, busy, reg_en, reg_we, reg_addr, reg_wdata}, '0);
    check_vec("async_reset_ct_data", ct_data, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_block(vecs[1], 1'b0, hs, ohs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

endmodule
